// File: rtl/instr_mem_stream_loader_pkg.sv
// Shared types and constants for the instruction memory stream loader.
package instr_mem_stream_loader_pkg;

    // Number of little-endian length bytes that precede the word stream.
    localparam int LEN_BYTES  = 4;
    localparam int DEF_WORD_W = 32;

    typedef logic [DEF_WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } load_state_e;

endpackage

// File: rtl/instr_mem_stream_loader_if.sv
// Loader byte stream plus the multi-port fetch bus of the instruction memory.
interface instr_mem_stream_loader_if #(
    parameter int WORD_W = 32,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 15
);
    logic                       load_start;
    logic                       load_valid;
    logic [7:0]                 load_data;
    logic                       load_ready;
    logic                       load_busy;
    logic                       load_done;
    logic                       load_err;
    logic [ADDR_W:0]            word_count;
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*WORD_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_valid;
    logic [NUM_RD-1:0]          rd_oob;

    // Host / core side.
    modport master (
        output load_start, load_valid, load_data, rd_en, rd_addr,
        input  load_ready, load_busy, load_done, load_err, word_count,
               rd_data, rd_valid, rd_oob
    );

    // Memory side.
    modport slave (
        input  load_start, load_valid, load_data, rd_en, rd_addr,
        output load_ready, load_busy, load_done, load_err, word_count,
               rd_data, rd_valid, rd_oob
    );
endinterface

// File: rtl/instr_mem_stream_loader_bram_1w1r.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module bram_1w1r #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port.
    // NOTE: the array has no reset; clearing it would prevent block-RAM inference and a reset must not erase the image.
    always_ff @(posedge i_clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read; holds the last fetched word when not enabled.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)  r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/instr_mem_stream_loader.sv
// Instruction memory loaded from a byte stream, with NUM_RD identical fetch banks.
module instr_mem_stream_loader
    import instr_mem_stream_loader_pkg::*;
#(
    parameter  int WORD_W = 32,
    parameter  int DEPTH  = 32768,
    parameter  int NUM_RD = 2,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BPW    = WORD_W / 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    instr_mem_stream_loader_if.slave bus
);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    load_state_e       r_state, w_next_state;
    logic [31:0]       r_len_q;
    logic [1:0]        r_len_idx;
    logic [IDX_W-1:0]  r_byte_idx;
    logic [WORD_W-1:0] r_asm;
    logic [ADDR_W:0]   r_word_count;
    logic [NUM_RD-1:0] r_rd_valid, r_rd_oob;

    logic              w_ready, w_done, w_fire, w_last_len, w_last_byte, w_we;
    logic [31:0]       w_len_full;
    logic [WORD_W-1:0] w_wdata;
    logic [NUM_RD-1:0] w_rd_fire, w_oob;

    assign w_ready     = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_ERR);
    assign w_done      = (r_state == ST_DONE);
    // A restart in the same cycle swallows whatever byte is on the bus.
    assign w_fire      = bus.load_valid & w_ready & ~bus.load_start;
    assign w_len_full  = {bus.load_data, r_len_q[31:8]};
    assign w_last_len  = (r_len_idx == 2'(LEN_BYTES - 1));
    assign w_last_byte = (r_byte_idx == IDX_W'(BPW - 1));
    assign w_we        = w_fire && (r_state == ST_DATA) && w_last_byte;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state decode; restart overrides everything else.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LEN: begin
                if (w_fire && w_last_len) begin
                    if (w_len_full == 32'd0)          w_next_state = ST_DONE;
                    else if (w_len_full > 32'(DEPTH)) w_next_state = ST_ERR;
                    else                              w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_we && (32'(r_word_count) + 32'd1 == r_len_q)) w_next_state = ST_DONE;
            end
            ST_IDLE, ST_DONE, ST_ERR: ;
            default: w_next_state = ST_IDLE;
        endcase
        if (bus.load_start) w_next_state = ST_LEN;
    end

    // Length shifter, byte assembler and word counter.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_len_q      <= '0;
            r_len_idx    <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_word_count <= '0;
        end else if (bus.load_start) begin
            r_len_q      <= '0;
            r_len_idx    <= '0;
            r_byte_idx   <= '0;
            r_word_count <= '0;
        end else if (w_fire && r_state == ST_LEN) begin
            r_len_q   <= w_len_full;
            r_len_idx <= r_len_idx + 2'd1;
        end else if (w_fire && r_state == ST_DATA) begin
            r_asm[8*r_byte_idx +: 8] <= bus.load_data;
            if (w_last_byte) begin
                r_byte_idx   <= '0;
                r_word_count <= r_word_count + 1'b1;
            end else begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end
        end
    end

    // Completed word: assembled low bytes plus the byte arriving now.
    always_comb begin
        w_wdata                 = r_asm;
        w_wdata[WORD_W-8 +: 8] = bus.load_data;
    end

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_port
            assign w_rd_fire[p] = bus.rd_en[p] & w_done & ~bus.load_start;
            assign w_oob[p]     = {1'b0, bus.rd_addr[p*ADDR_W +: ADDR_W]} >= r_word_count;

            bram_1w1r #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_bank (
                .i_clock (i_clock),
                .i_reset (i_reset),
                .i_we    (w_we),
                .i_waddr (r_word_count[ADDR_W-1:0]),
                .i_wdata (w_wdata),
                .i_re    (w_rd_fire[p]),
                .i_raddr (bus.rd_addr[p*ADDR_W +: ADDR_W]),
                .o_rdata (bus.rd_data[p*WORD_W +: WORD_W])
            );
        end
    endgenerate

    // Per-port fetch status, aligned with the bank read register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_valid <= '0;
            r_rd_oob   <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_oob   <= w_rd_fire & w_oob;
        end
    end

    assign bus.load_ready = w_ready;
    assign bus.load_busy  = (r_state == ST_LEN) || (r_state == ST_DATA);
    assign bus.load_done  = w_done;
    assign bus.load_err   = (r_state == ST_ERR);
    assign bus.word_count = r_word_count;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_oob     = r_rd_oob;
endmodule

// File: tb/tb_instr_mem_stream_loader.sv
// Randomised self-checking bench for instr_mem_stream_loader against a word-array model.
module tb_instr_mem_stream_loader;
    import instr_mem_stream_loader_pkg::*;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_RD = 2;
    localparam int ADDR_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_mem_stream_loader_if #(.WORD_W(WORD_W), .NUM_RD(NUM_RD), .ADDR_W(ADDR_W)) bus ();

    instr_mem_stream_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;

    // Reference model: what each bank should hold and how many words are loaded.
    word_t       model_mem   [DEPTH];
    bit          model_known [DEPTH];
    int unsigned model_count;
    word_t       img         [DEPTH];
    word_t       exp_last    [NUM_RD];
    bit          have_last   [NUM_RD];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic send_count(input int unsigned c);
        for (int i = 0; i < 4; i++) send_byte(8'(c >> (8 * i)));
    endtask

    task automatic send_words(input int n);
        for (int w = 0; w < n; w++)
            for (int b = 0; b < WORD_W / 8; b++) send_byte(8'(img[w] >> (8 * b)));
    endtask

    task automatic commit(input int n);
        for (int i = 0; i < n; i++) begin
            model_mem[i]   = img[i];
            model_known[i] = 1'b1;
        end
        model_count = n;
    endtask

    task automatic read2(input logic [1:0] en, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        bus.rd_en   = en;
        bus.rd_addr = {a1, a0};
        tick();
        bus.rd_en   = '0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if ({bus.load_ready, bus.load_busy, bus.load_done, bus.load_err} !== 4'b0000) begin n_errors++; $display("FAIL reset_status: got %b want 0000", {bus.load_ready, bus.load_busy, bus.load_done, bus.load_err}); end
        n_checks++; if (bus.word_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", bus.word_count); end
        n_checks++; if ({bus.rd_valid, bus.rd_oob} !== 4'b0000) begin n_errors++; $display("FAIL reset_rd_flags: got %b want 0000", {bus.rd_valid, bus.rd_oob}); end
        n_checks++; if (bus.rd_data !== '0) begin n_errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        img[0] = 32'h11223344; img[1] = 32'hAABBCCDD; img[2] = 32'h00000013;
        pulse_start();
        n_checks++; if ({bus.load_ready, bus.load_busy} !== 2'b11) begin n_errors++; $display("FAIL basic_len_flags: got %b want 11", {bus.load_ready, bus.load_busy}); end
        send_count(3);
        send_words(3);
        commit(3);
        n_checks++; if ({bus.load_ready, bus.load_busy, bus.load_done, bus.load_err} !== 4'b0010) begin n_errors++; $display("FAIL basic_done_flags: got %b want 0010", {bus.load_ready, bus.load_busy, bus.load_done, bus.load_err}); end
        n_checks++; if (bus.word_count !== 5'd3) begin n_errors++; $display("FAIL basic_count: got %0d want 3", bus.word_count); end
        read2(2'b01, 4'd1, 4'd0);
        n_checks++; if ({bus.rd_valid, bus.rd_oob} !== 4'b0100) begin n_errors++; $display("FAIL basic_rd_flags: got %b want 0100", {bus.rd_valid, bus.rd_oob}); end
        n_checks++; if (bus.rd_data[31:0] !== 32'hAABBCCDD) begin n_errors++; $display("FAIL basic_rd_data: got %h want aabbccdd", bus.rd_data[31:0]); end
    endtask

    task automatic test_dual_port();
        read2(2'b11, 4'd0, 4'd5);
        n_checks++; if ({bus.rd_valid, bus.rd_oob} !== 4'b1110) begin n_errors++; $display("FAIL dual_rd_flags: got %b want 1110", {bus.rd_valid, bus.rd_oob}); end
        n_checks++; if (bus.rd_data[31:0] !== model_mem[0]) begin n_errors++; $display("FAIL dual_rd_data0: got %h want %h", bus.rd_data[31:0], model_mem[0]); end
    endtask

    task automatic test_drop_in_done();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.load_ready !== 1'b0) begin n_errors++; $display("FAIL done_ready: got %b want 0", bus.load_ready); end
            send_byte(8'($urandom));
        end
        n_checks++; if (bus.word_count !== 5'(model_count)) begin n_errors++; $display("FAIL done_drop_count: got %0d want %0d", bus.word_count, model_count); end
        read2(2'b10, 4'd0, 4'd2);
        n_checks++; if (bus.rd_data[63:32] !== model_mem[2]) begin n_errors++; $display("FAIL done_drop_data: got %h want %h", bus.rd_data[63:32], model_mem[2]); end
    endtask

    task automatic test_overflow();
        pulse_start();
        send_count(DEPTH + 1);
        model_count = 0;
        n_checks++; if ({bus.load_ready, bus.load_busy, bus.load_done, bus.load_err} !== 4'b1001) begin n_errors++; $display("FAIL ovf_flags: got %b want 1001", {bus.load_ready, bus.load_busy, bus.load_done, bus.load_err}); end
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        n_checks++; if ({bus.load_ready, bus.load_err, bus.word_count} !== {2'b11, 5'd0}) begin n_errors++; $display("FAIL ovf_after_bytes: got %b want 1100000", {bus.load_ready, bus.load_err, bus.word_count}); end
        read2(2'b11, 4'd0, 4'd1);
        n_checks++; if (bus.rd_valid !== 2'b00) begin n_errors++; $display("FAIL ovf_rd_valid: got %b want 00", bus.rd_valid); end
    endtask

    task automatic test_zero_count();
        pulse_start();
        send_count(0);
        commit(0);
        n_checks++; if ({bus.load_done, bus.word_count} !== {1'b1, 5'd0}) begin n_errors++; $display("FAIL zero_done: got %b want 100000", {bus.load_done, bus.word_count}); end
        read2(2'b11, 4'd0, 4'($urandom_range(0, DEPTH - 1)));
        n_checks++; if ({bus.rd_valid, bus.rd_oob} !== 4'b1111) begin n_errors++; $display("FAIL zero_rd_flags: got %b want 1111", {bus.rd_valid, bus.rd_oob}); end
        n_checks++; if (bus.rd_data[31:0] !== model_mem[0]) begin n_errors++; $display("FAIL zero_raw_data: got %h want %h", bus.rd_data[31:0], model_mem[0]); end
    endtask

    task automatic test_restart_final_byte();
        img[0] = word_t'($urandom);
        pulse_start();
        send_count(1);
        for (int b = 0; b < 3; b++) send_byte(8'(img[0] >> (8 * b)));
        bus.load_start = 1'b1;
        send_byte(img[0][31:24]);
        bus.load_start = 1'b0;
        n_checks++; if ({bus.load_busy, bus.load_done, bus.word_count} !== {2'b10, 5'd0}) begin n_errors++; $display("FAIL restart_last_state: got %b want 1000000", {bus.load_busy, bus.load_done, bus.word_count}); end
        send_count(0);
        commit(0);
        read2(2'b01, 4'd0, 4'd0);
        n_checks++; if ({bus.rd_valid[0], bus.rd_oob[0]} !== 2'b11) begin n_errors++; $display("FAIL restart_last_flags: got %b want 11", {bus.rd_valid[0], bus.rd_oob[0]}); end
        n_checks++; if (bus.rd_data[31:0] !== model_mem[0]) begin n_errors++; $display("FAIL restart_last_nowrite: got %h want %h", bus.rd_data[31:0], model_mem[0]); end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_count(1);
        send_byte(8'hEF);
        send_byte(8'hBE);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.load_ready, bus.load_busy, bus.load_done, bus.load_err, bus.word_count} !== 9'd0) begin n_errors++; $display("FAIL midrst_status: got %b want 0", {bus.load_ready, bus.load_busy, bus.load_done, bus.load_err, bus.word_count}); end
        n_checks++; if ({bus.rd_data, bus.rd_valid, bus.rd_oob} !== '0) begin n_errors++; $display("FAIL midrst_rd: got %h want 0", {bus.rd_data, bus.rd_valid, bus.rd_oob}); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        img[0] = 32'hDEADBEEF;
        pulse_start();
        send_count(1);
        send_words(1);
        commit(1);
        n_checks++; if ({bus.load_done, bus.word_count} !== {1'b1, 5'd1}) begin n_errors++; $display("FAIL midrst_reload: got %b want 100001", {bus.load_done, bus.word_count}); end
        read2(2'b10, 4'd3, 4'd0);
        n_checks++; if ({bus.rd_valid[1], bus.rd_oob[1], bus.rd_data[63:32]} !== {2'b10, 32'hDEADBEEF}) begin n_errors++; $display("FAIL midrst_rd_data: got %h want 2deadbeef", {bus.rd_valid[1], bus.rd_oob[1], bus.rd_data[63:32]}); end
    endtask

    task automatic test_restart_in_done();
        bus.load_start = 1'b1;
        bus.rd_en      = 2'b11;
        tick();
        bus.load_start = 1'b0;
        bus.rd_en      = 2'b00;
        n_checks++; if (bus.rd_valid !== 2'b00) begin n_errors++; $display("FAIL rst_done_valid: got %b want 00", bus.rd_valid); end
        n_checks++; if ({bus.load_ready, bus.load_done, bus.word_count} !== {2'b10, 5'd0}) begin n_errors++; $display("FAIL rst_done_flags: got %b want 1000000", {bus.load_ready, bus.load_done, bus.word_count}); end
        img[0] = word_t'($urandom);
        img[1] = word_t'($urandom);
        send_count(2);
        send_words(2);
        commit(2);
        read2(2'b11, 4'd0, 4'd1);
        n_checks++; if (bus.rd_data !== {model_mem[1], model_mem[0]}) begin n_errors++; $display("FAIL rst_done_newimg: got %h want %h", bus.rd_data, {model_mem[1], model_mem[0]}); end
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < DEPTH; i++) img[i] = word_t'($urandom);
        pulse_start();
        send_count(DEPTH);
        send_words(DEPTH);
        commit(DEPTH);
        n_checks++; if ({bus.load_done, bus.load_err, bus.word_count} !== {2'b10, 5'(DEPTH)}) begin n_errors++; $display("FAIL full_status: got %b want 1010000", {bus.load_done, bus.load_err, bus.word_count}); end
        read2(2'b11, 4'(DEPTH - 1), 4'd0);
        n_checks++; if ({bus.rd_valid, bus.rd_oob} !== 4'b1100) begin n_errors++; $display("FAIL full_rd_flags: got %b want 1100", {bus.rd_valid, bus.rd_oob}); end
        n_checks++; if (bus.rd_data !== {model_mem[0], model_mem[DEPTH-1]}) begin n_errors++; $display("FAIL full_rd_data: got %h want %h", bus.rd_data, {model_mem[0], model_mem[DEPTH-1]}); end
        for (int p = 0; p < NUM_RD; p++) have_last[p] = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]        en;
        logic [ADDR_W-1:0] a [NUM_RD];
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) img[i] = word_t'($urandom);
            pulse_start();
            send_count(n);
            send_words(n);
            commit(n);
            n_checks++; if ({bus.load_done, bus.word_count} !== {1'b1, 5'(n)}) begin n_errors++; $display("FAIL rand_load it=%0d: got %b want done with %0d", it, {bus.load_done, bus.word_count}, n); end
            for (int r = 0; r < 10; r++) begin
                en = 2'($urandom);
                for (int p = 0; p < NUM_RD; p++) a[p] = 4'($urandom);
                read2(en, a[0], a[1]);
                for (int p = 0; p < NUM_RD; p++) begin
                    if (en[p]) begin
                        exp_last[p]  = model_mem[a[p]];
                        have_last[p] = model_known[a[p]];
                    end
                    n_checks++; if ({bus.rd_valid[p], bus.rd_oob[p]} !== {en[p], en[p] && (32'(a[p]) >= model_count)}) begin n_errors++; $display("FAIL rand_flags p=%0d addr=%0d: got %b want en=%b cnt=%0d", p, a[p], {bus.rd_valid[p], bus.rd_oob[p]}, en[p], model_count); end
                    if (have_last[p]) begin
                        n_checks++; if (bus.rd_data[p*WORD_W +: WORD_W] !== exp_last[p]) begin n_errors++; $display("FAIL rand_data p=%0d: got %h want %h", p, bus.rd_data[p*WORD_W +: WORD_W], exp_last[p]); end
                    end
                end
            end
        end
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.rd_en      = '0;
        bus.rd_addr    = '0;
        model_count    = 0;
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
        for (int p = 0; p < NUM_RD; p++) have_last[p] = 1'b0;

        test_reset();
        test_basic_load();
        test_dual_port();
        test_drop_in_done();
        test_overflow();
        test_zero_count();
        test_restart_final_byte();
        test_reset_mid_load();
        test_restart_in_done();
        test_full_depth();
        test_random();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
